// File: rtl/scalar_writeback.sv
// scalar_writeback: per-warp scalar register writeback sequencer; SCALAR_WB_BYPASS_EN enables response bypass on hazards
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package scalar_wb_pkg;
    typedef enum logic [2:0] {ALU_OUT, IMMEDIATE, PC_PLUS_1, VEC_TO_SCALAR, LSU_OUT} reg_input_mux_t;
endpackage

module scalar_writeback
    import scalar_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int PENDING_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_issue_valid,
    output logic                  o_issue_ready,
    input  logic                  i_issue_reg_write_enable,
    input  reg_input_mux_t        i_issue_src,
    input  logic [4:0]            i_issue_rd,
    input  logic [DATA_WIDTH-1:0] i_issue_data,
    input  logic [4:0]            i_hazard_rs1,
    input  logic [4:0]            i_hazard_rs2,
    output logic                  o_hazard,
    input  logic                  i_lsu_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_lsu_resp_data,
    output logic                  o_wb_valid,
    output logic [4:0]            o_wb_rd,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_err_unexpected_resp
);
    localparam int PW = $clog2(PENDING_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]               r_fifo_rd [PENDING_DEPTH];
    logic [PENDING_DEPTH-1:0] r_fifo_disc;
    logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic [31:0]              r_pending;
    logic                     r_skid_valid;
    logic [4:0]               r_skid_rd;
    logic [DATA_WIDTH-1:0]    r_skid_data;
    logic                     r_wb_valid;
    logic [4:0]               r_wb_rd;
    logic [DATA_WIDTH-1:0]    r_wb_data;
    logic                     r_err;

    logic        w_fifo_empty, w_fifo_full, w_head_disc, w_pop, w_resp_wr;
    logic [4:0]  w_head_rd;
    logic [31:0] w_clr, w_set, w_bypass, w_pend_eff;
    logic        w_waw, w_skid_hit, w_accept, w_is_lsu, w_push, w_push_disc, w_alu_wr;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(PENDING_DEPTH));
    assign w_head_rd    = r_fifo_rd[r_rd_ptr];
    assign w_head_disc  = r_fifo_disc[r_rd_ptr];
    assign w_pop        = i_lsu_resp_valid && !w_fifo_empty;
    assign w_resp_wr    = w_pop && !w_head_disc;
    assign w_clr        = w_resp_wr ? (32'd1 << w_head_rd) : '0;
`ifdef SCALAR_WB_BYPASS_EN
    assign w_bypass     = w_clr;
`else
    assign w_bypass     = '0;
`endif
    assign w_pend_eff   = r_pending & ~w_bypass;
    assign w_waw        = i_issue_reg_write_enable && (i_issue_rd != 5'd0) && w_pend_eff[i_issue_rd];
    // a response popping this cycle frees a slot, so a full FIFO can still take a push
    assign o_issue_ready = !(w_fifo_full && !w_pop) && !r_skid_valid && !w_waw;
    assign w_skid_hit   = r_skid_valid && (r_skid_rd == i_hazard_rs1 || r_skid_rd == i_hazard_rs2);
    assign o_hazard     = ((i_hazard_rs1 != 5'd0) && w_pend_eff[i_hazard_rs1]) ||
                          ((i_hazard_rs2 != 5'd0) && w_pend_eff[i_hazard_rs2]) || w_skid_hit;
    assign w_accept     = i_issue_valid && o_issue_ready && i_enable;
    assign w_is_lsu     = (i_issue_src == LSU_OUT);
    assign w_push       = w_accept && w_is_lsu;
    assign w_push_disc  = !i_issue_reg_write_enable || (i_issue_rd == 5'd0);
    assign w_alu_wr     = w_accept && !w_is_lsu && i_issue_reg_write_enable && (i_issue_rd != 5'd0);
    assign w_set        = (w_push && !w_push_disc) ? (32'd1 << i_issue_rd) : '0;

    assign o_wb_valid            = r_wb_valid;
    assign o_wb_rd               = r_wb_rd;
    assign o_wb_data             = r_wb_data;
    assign o_err_unexpected_resp = r_err;

    // in-order pending-load FIFO; push and pop are independent so both land in one cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]   <= i_issue_rd;
                r_fifo_disc[r_wr_ptr] <= w_push_disc;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // scoreboard: a new load's set wins over a same-cycle clear of that register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr) | w_set;
    end

    // write port: load response, then skid, then a fresh single-cycle result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_rd    <= '0;
            r_skid_data  <= '0;
        end else if (w_resp_wr) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_head_rd;
            r_wb_data  <= i_lsu_resp_data;
            if (w_alu_wr) begin
                r_skid_valid <= 1'b1;
                r_skid_rd    <= i_issue_rd;
                r_skid_data  <= i_issue_data;
            end
        end else if (r_skid_valid) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd      <= r_skid_rd;
            r_wb_data    <= r_skid_data;
            r_skid_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_alu_wr;
            if (w_alu_wr) begin
                r_wb_rd   <= i_issue_rd;
                r_wb_data <= i_issue_data;
            end
        end
    end

    // sticky flag for a response with nothing outstanding
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (i_lsu_resp_valid && w_fifo_empty)
            r_err <= 1'b1;
    end
endmodule
